// File: rtl/digits_frame_streamer_if.sv
// Pixel byte stream from the frame streamer to the SSD1306 data sender.
// Carries the byte, its valid/ready handshake and the page/frame markers.
interface digits_frame_streamer_if;
  logic [7:0] data_out;
  logic       data_valid_out;
  logic       data_ready_in;
  logic       page_start_out;
  logic       last_out;

  modport master (
    output data_out,
    output data_valid_out,
    output page_start_out,
    output last_out,
    input  data_ready_in
  );

  modport slave (
    input  data_out,
    input  data_valid_out,
    input  page_start_out,
    input  last_out,
    output data_ready_in
  );
endinterface

// File: rtl/digits_frame_streamer.sv
// Walks page/digit/column over a segment snapshot, drives the glyph decoder
// and streams its column bytes in SSD1306 page-addressing order.
module digits_frame_streamer #(
  parameter int DIGITS      = 6,
  parameter int DIGIT_WIDTH = 21
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic [7*DIGITS-1:0]   segments_in,
  output logic [6:0]            dec_segments_out,
  output logic [4:0]            dec_index_x_out,
  output logic [1:0]            dec_index_y_out,
  input  logic [7:0]            dec_pixels_in,
  digits_frame_streamer_if.master stream,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic [4:0]          col;
  logic [DIG_W-1:0]    dig;
  logic [1:0]          page;
  logic [7*DIGITS-1:0] snap;

  logic col_end, dig_end, page_end, at_final;
  logic load_en, handshake;

  assign col_end   = (col == 5'(DIGIT_WIDTH-1));
  assign dig_end   = (dig == DIG_W'(DIGITS-1));
  assign page_end  = (page == 2'd3);
  assign at_final  = col_end && dig_end && page_end;
  assign handshake = stream.data_valid_out && stream.data_ready_in;
  assign load_en   = (state == STREAM) &&
                     (!stream.data_valid_out || stream.data_ready_in);

  assign dec_index_x_out = col;
  assign dec_index_y_out = page;
  assign busy_out        = (state != IDLE);

  always_comb begin
    dec_segments_out = '0;
    for (int d = 0; d < DIGITS; d++)
      if (dig == DIG_W'(d))
        dec_segments_out = snap[7*d +: 7];
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_in)            state_next = STREAM;
      STREAM:  if (load_en && at_final) state_next = DRAIN;
      DRAIN:   if (handshake)           state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      col                   <= '0;
      dig                   <= '0;
      page                  <= '0;
      snap                  <= '0;
      stream.data_out       <= '0;
      stream.data_valid_out <= 1'b0;
      stream.page_start_out <= 1'b0;
      stream.last_out       <= 1'b0;
      done_out              <= 1'b0;
    end else begin
      done_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_in) begin
            snap <= segments_in;
            col  <= '0;
            dig  <= '0;
            page <= '0;
          end
        end
        STREAM: begin
          if (load_en) begin
            stream.data_out       <= dec_pixels_in;
            stream.data_valid_out <= 1'b1;
            stream.page_start_out <= (col == '0) && (dig == '0);
            stream.last_out       <= at_final;
            // Counters hold on the final byte so the decoder inputs stay put.
            if (!at_final) begin
              if (!col_end) begin
                col <= col + 5'd1;
              end else begin
                col <= '0;
                if (!dig_end) begin
                  dig <= dig + DIG_W'(1);
                end else begin
                  dig  <= '0;
                  page <= page + 2'd1;
                end
              end
            end
          end
        end
        DRAIN: begin
          if (handshake) begin
            stream.data_valid_out <= 1'b0;
            stream.last_out       <= 1'b0;
            done_out              <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digits_frame_streamer.sv
// Bench for digits_frame_streamer: stub decoder, random backpressure,
// frame-level reference model built from page/digit/column order.
module tb_digits_frame_streamer;

  localparam int DIGITS = 6;
  localparam int DW     = 21;
  localparam int FRAME  = 4 * DIGITS * DW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [41:0] segs = '0;
  logic [6:0]  dec_seg;
  logic [4:0]  dec_x;
  logic [1:0]  dec_y;
  logic [7:0]  dec_pix;
  logic        busy;
  logic        done;

  digits_frame_streamer_if sif ();

  digits_frame_streamer #(.DIGITS(DIGITS), .DIGIT_WIDTH(DW)) dut (
    .clk_in           (clk),
    .reset_in         (rst),
    .start_in         (start),
    .segments_in      (segs),
    .dec_segments_out (dec_seg),
    .dec_index_x_out  (dec_x),
    .dec_index_y_out  (dec_y),
    .dec_pixels_in    (dec_pix),
    .stream           (sif),
    .busy_out         (busy),
    .done_out         (done)
  );

  assign dec_pix = {dec_seg[0], dec_y, dec_x};

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // word layout: {data[7:0], page_start, last}
  logic [9:0] exp_q[$];
  logic [9:0] got[$];
  int done_cnt;
  int stall_err;
  logic done_ok;
  logic timed_out;

  function automatic logic [9:0] cur_word();
    return {sif.data_out, sif.page_start_out, sif.last_out};
  endfunction

  task automatic build_exp(input logic [41:0] s);
    exp_q.delete();
    for (int p = 0; p < 4; p++)
      for (int d = 0; d < DIGITS; d++)
        for (int c = 0; c < DW; c++)
          exp_q.push_back({s[7*d], 2'(p), 5'(c),
                           (c == 0 && d == 0),
                           (p == 3 && d == DIGITS-1 && c == DW-1)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Accepts bytes with pct% ready until done, max_bytes, or the cycle budget.
  task automatic collect(input int pct, input int max_bytes, input int budget);
    logic pv, pr;
    logic [9:0] pw;
    int cyc;
    got.delete();
    done_cnt  = 0;
    stall_err = 0;
    done_ok   = 1'b0;
    timed_out = 1'b0;
    cyc = 0;
    pv = sif.data_valid_out;
    pw = cur_word();
    pr = ($urandom_range(99) < pct);
    sif.data_ready_in = pr;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (done) done_cnt++;
      if (pv && pr) begin
        got.push_back(pw);
        if (pw[0]) done_ok = done;
      end else if (pv && !pr) begin
        if (!sif.data_valid_out || cur_word() !== pw) stall_err++;
      end
      if (done || got.size() >= max_bytes) break;
      if (cyc >= budget) begin
        timed_out = 1'b1;
        break;
      end
      pv = sif.data_valid_out;
      pw = cur_word();
      pr = ($urandom_range(99) < pct);
      sif.data_ready_in = pr;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    sif.data_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({sif.data_valid_out, sif.page_start_out, sif.last_out, busy, done}
        !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 00000",
               {sif.data_valid_out, sif.page_start_out, sif.last_out, busy, done});
    end
    n_cmp++;
    if ({sif.data_out, dec_seg, dec_x, dec_y} !== 22'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0",
               {sif.data_out, dec_seg, dec_x, dec_y});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || sif.data_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0",
               busy, sif.data_valid_out);
    end
  endtask

  task automatic test_basic();
    segs = '0;
    for (int d = 0; d < DIGITS; d += 2) segs[7*d] = 1'b1;
    build_exp(segs);
    sif.data_ready_in = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (sif.data_valid_out !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL latency_e0: valid=%b busy=%b want 0 1",
               sif.data_valid_out, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (!sif.data_valid_out || cur_word() !== 10'b1000_0000_10) begin
      n_err++;
      $display("FAIL first_byte: valid=%b word=%h want 1 %h",
               sif.data_valid_out, cur_word(), 10'b1000_0000_10);
    end
    collect(100, FRAME, 2000);
    n_cmp++;
    if (timed_out || got.size() != FRAME) begin
      n_err++;
      $display("FAIL basic_count: got %0d bytes timeout=%b want %0d",
               got.size(), timed_out, FRAME);
    end
    for (int i = 0; i < got.size() && i < FRAME; i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL basic_byte[%0d]: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (got.size() == FRAME && got[FRAME-1] !== {8'h74, 2'b01}) begin
      n_err++;
      $display("FAIL last_byte: got %h want %h", got[FRAME-1], {8'h74, 2'b01});
    end
    n_cmp++;
    if (done_ok !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: done=%b busy=%b want 1 0", done_ok, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL done_width: got %b want 0", done);
    end
  endtask

  task automatic test_backpressure();
    segs = 42'({$urandom(), $urandom()});
    build_exp(segs);
    pulse_start();
    collect(50, FRAME, 6000);
    n_cmp++;
    if (timed_out || got.size() != FRAME || done_cnt != 1) begin
      n_err++;
      $display("FAIL bp_count: bytes=%0d dones=%0d timeout=%b want %0d 1 0",
               got.size(), done_cnt, timed_out, FRAME);
    end
    n_cmp++;
    if (stall_err != 0) begin
      n_err++;
      $display("FAIL bp_stall_hold: got %0d changes want 0", stall_err);
    end
    for (int i = 0; i < got.size() && i < FRAME; i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL bp_byte[%0d]: got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_frame_inputs();
    logic [41:0] orig;
    orig = 42'({$urandom(), $urandom()});
    segs = orig;
    build_exp(orig);
    pulse_start();
    fork
      collect(70, FRAME, 6000);
      begin
        repeat (60) @(posedge clk);
        #2;
        start = 1'b1;
        segs = ~orig;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (150) @(posedge clk);
        #2;
        start = 1'b1;
        segs = 42'({$urandom(), $urandom()});
        @(posedge clk); #2;
        start = 1'b0;
      end
    join
    n_cmp++;
    if (timed_out || got.size() != FRAME || done_cnt != 1) begin
      n_err++;
      $display("FAIL mid_count: bytes=%0d dones=%0d want %0d 1",
               got.size(), done_cnt, FRAME);
    end
    for (int i = 0; i < got.size() && i < FRAME; i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL mid_byte[%0d]: got %h want %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int dones;
    segs = 42'({$urandom(), $urandom()});
    build_exp(segs);
    pulse_start();
    collect(50, 200, 3000);
    n_cmp++;
    if (got.size() != 200) begin
      n_err++;
      $display("FAIL rst_prefix_count: got %0d want 200", got.size());
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({sif.data_valid_out, busy, sif.page_start_out, sif.last_out, done}
        !== 5'b0) begin
      n_err++;
      $display("FAIL rst_mid_flags: got %b want 00000",
               {sif.data_valid_out, busy, sif.page_start_out, sif.last_out, done});
    end
    rst = 1'b0;
    dones = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done || sif.data_valid_out) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL rst_no_done: got %0d active cycles want 0", dones);
    end
    segs = 42'({$urandom(), $urandom()});
    build_exp(segs);
    pulse_start();
    collect(80, FRAME, 4000);
    n_cmp++;
    if (timed_out || got.size() != FRAME) begin
      n_err++;
      $display("FAIL rst_refill_count: got %0d want %0d", got.size(), FRAME);
    end
    for (int i = 0; i < got.size() && i < FRAME; i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL rst_refill_byte[%0d]: got %h want %h",
                 i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stall_last();
    segs = 42'({$urandom(), $urandom()});
    build_exp(segs);
    pulse_start();
    collect(100, FRAME-1, 2000);
    sif.data_ready_in = 1'b0;
    n_cmp++;
    if (got.size() != FRAME-1) begin
      n_err++;
      $display("FAIL stall_prefix: got %0d want %0d", got.size(), FRAME-1);
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (!sif.data_valid_out || done || cur_word() !== exp_q[FRAME-1]) begin
        n_err++;
        $display("FAIL stall_last_hold[%0d]: valid=%b done=%b word=%h want 1 0 %h",
                 k, sif.data_valid_out, done, cur_word(), exp_q[FRAME-1]);
      end
    end
    sif.data_ready_in = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b1 || sif.data_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL stall_release: done=%b valid=%b want 1 0",
               done, sif.data_valid_out);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL stall_done_width: got %b want 0", done);
    end
  endtask

  task automatic test_back_to_back();
    segs = 42'({$urandom(), $urandom()});
    build_exp(segs);
    start = 1'b1;
    collect(100, FRAME, 2000);
    n_cmp++;
    if (timed_out || got.size() != FRAME || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first: bytes=%0d busy=%b want %0d 0",
               got.size(), busy, FRAME);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1 || sif.data_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_restart: busy=%b valid=%b want 1 0",
               busy, sif.data_valid_out);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (!sif.data_valid_out || cur_word() !== exp_q[0]) begin
      n_err++;
      $display("FAIL b2b_first_byte: valid=%b word=%h want 1 %h",
               sif.data_valid_out, cur_word(), exp_q[0]);
    end
    collect(100, FRAME, 2000);
    start = 1'b0;
    n_cmp++;
    if (timed_out || got.size() != FRAME || done_ok !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_second: bytes=%0d done=%b want %0d 1",
               got.size(), done_ok, FRAME);
    end
    for (int i = 0; i < got.size() && i < FRAME; i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL b2b_byte[%0d]: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_stop: busy=%b want 0", busy);
    end
  endtask

  initial begin
    sif.data_ready_in = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_mid_frame_inputs();
    test_reset_mid_frame();
    test_stall_last();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/digits_frame_streamer.md
# digits_frame_streamer

Scan sequencer feeding the 7-segment to 21x32-pixel glyph decoder and handing its pixel bytes to the SSD1306 data sender. On a start pulse it latches a snapshot of all digit segment codes. It then walks page, digit and column order, driving the decoder's segment and index inputs and capturing the returned 8-pixel column byte. The bytes go out as a valid/ready stream in SSD1306 page-addressing order, with page-start and frame-last markers.

## Interface
Parameters:
- DIGITS, 6: number of 21-pixel-wide digits per row; DIGITS*21 ≤ 128.
- DIGIT_WIDTH, 21: columns per digit; fixed to decoder width, not to be overridden.

Ports:
- clk_in, input, 1: single clock, all logic on rising edge.
- reset_in, input, 1: synchronous, active-high reset.
- start_in, input, 1: frame request; honoured only in IDLE.
- segments_in, input, 7*DIGITS: digit d code at [7*d +: 7], bit order {g,f,e,d,c,b,a}; digit 0 leftmost.
- dec_segments_out, output, 7: current digit code to decoder.
- dec_index_x_out, output, 5: column within digit, 0..20.
- dec_index_y_out, output, 2: page 0..3.
- dec_pixels_in, input, 8: decoder result (combinational from the three outputs above).
- data_out, output, 8: pixel byte, LSB = top pixel of page.
- data_valid_out, output, 1: data_out holds an unconsumed byte.
- data_ready_in, input, 1: downstream accepts byte when valid&&ready at edge.
- page_start_out, output, 1: qualifies data_out; first byte of a page (column 0 of digit 0).
- last_out, output, 1: qualifies data_out; final byte of frame.
- busy_out, output, 1: high in STREAM and DRAIN.
- done_out, output, 1: one-cycle pulse after last byte accepted.

## Operation
- Reset values: state IDLE, counters 0, segment snapshot 0, data_out 0x00, data_valid_out 0, page_start_out 0, last_out 0, busy_out 0, done_out 0. Decoder outputs are then 0.
- Counters:
  - col: 0..DIGIT_WIDTH-1.
  - dig: 0..DIGITS-1.
  - page: 0..3.
  - col is innermost, then dig, then page.
  - dec_index_x_out = col.
  - dec_index_y_out = page.
  - dec_segments_out = snapshot[7*dig +: 7].
- Frame = 4*DIGITS*DIGIT_WIDTH bytes, which is 504 for the defaults.
- Output register: a single stage that loads when "load_en" = STREAM && (!data_valid_out || data_ready_in).
- States:
  - IDLE: on start_in, latch segments_in into the snapshot, clear counters, go STREAM. Otherwise hold, with data_valid_out 0.
  - STREAM: on load_en:
    - data_out <= dec_pixels_in.
    - data_valid_out <= 1.
    - page_start_out <= (col==0 && dig==0).
    - last_out <= (page==3 && dig==DIGITS-1 && col==DIGIT_WIDTH-1).
    - Counters advance. At the final position, go DRAIN without wrapping (counters hold).
    - If valid && ready && !load_en, which cannot occur in STREAM, there is no case.
  - DRAIN: on valid && ready, data_valid_out <= 0, last_out <= 0, done_out <= 1, go IDLE.
- In IDLE, a handshake on a still-valid byte is impossible; valid is always 0 there.
- start_in outside IDLE is ignored. The snapshot is stable for the whole frame, and changes on segments_in mid-frame have no effect.
- data_out, page_start_out and last_out hold stable while valid && !ready.
- reset_in mid-frame: next cycle all outputs are at reset values and the partial frame is abandoned. There is no done_out.

## Timing
- start_in sampled at edge E0, then STREAM from E0.
- First byte valid after E1, so latency is 2 edges from start to data_valid_out.
- With data_ready_in held high: 1 byte/cycle, and the last byte is valid after E504.
- done_out is high for the cycle after edge E505 (the last handshake edge), and the block is back in IDLE in that same cycle.
- start_in asserted in the done_out cycle is accepted (state IDLE).
- Backpressure: while valid && !ready, the counters and decoder outputs freeze.
- The decoder path is purely combinational within one cycle. No other pipelining.

## Test plan
All scenarios use a bench stub decoder: pixels = {seg[0], page[1:0], col[4:0]}. DIGITS=6.
- Reset, then start with segments_in alternating bit0 per digit (digits 0, 2, 4 = 7'h01, others 0), ready=1. Expect:
  - 504 bytes, byte n = {dig(n)%2==0, page, col} in page/digit/column order.
  - First byte 0x80 two edges after start.
  - page_start_out on bytes 0, 126, 252 and 378.
  - last_out only on byte 503 (0x74).
  - done_out pulse the cycle after.
- Random data_ready_in (50%). Expect the identical byte sequence, with data_out and flags held while stalled and no byte dropped or duplicated.
- start_in pulsed during STREAM and segments_in changed mid-frame. Expect no restart and the stream unchanged from the original snapshot.
- reset_in asserted at byte 200. Expect valid, busy_out and flags low next cycle and no done_out. A new start then gives a full 504-byte frame from byte 0.
- data_ready_in held 0 at the last byte for 10 cycles. Expect last_out and valid held and done_out absent; when ready rises, done_out pulses one cycle later.
- start_in held high continuously. Expect back-to-back frames, each starting 1 cycle after the previous done_out cycle.
